rgb_led_sched: RTL and testbench



---
 rtl/rgb_sched_pkg.sv | 15 +
 rtl/rgb_pwm_gen.sv | 47 ++++
 rtl/rgb_led_sched.sv | 141 ++++++++++++++
 tb/tb_rgb_led_sched.sv | 134 +++++++++++++
 4 files changed

// File: rtl/rgb_sched_pkg.sv
// rgb_sched_pkg: shared types, duty field layout and breathe scaling helper for the RGB LED scheduler
package rgb_sched_pkg;
  typedef enum logic [1:0] {MODE_SOLID, MODE_BLINK, MODE_BREATHE, MODE_RSVD} mode_t;
  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} state_t;
  localparam int DUTY_W = 8;
  localparam int G_OFS  = 0;
  localparam int B_OFS  = 8;
  localparam int R_OFS  = 16;
  // (d*lvl)>>8 on a full-width product, so lvl=255 gives at most 254
  function automatic logic [DUTY_W-1:0] scale_duty(input logic [DUTY_W-1:0] d, input logic [DUTY_W-1:0] lvl);
    logic [2*DUTY_W-1:0] p;
    p = {{DUTY_W{1'b0}}, d} * {{DUTY_W{1'b0}}, lvl};
    return p[2*DUTY_W-1:DUTY_W];
  endfunction
endpackage

// File: rtl/rgb_pwm_gen.sv
// rgb_pwm_gen: prescaler, 8-bit PWM frame counter and registered per-channel comparators
//   hw_clk, rst_n         clock, async active-low reset
//   en                    channels may go high only while en=1
//   duty_g/duty_b/duty_r  8-bit duty per channel
//   frame_end             last clock of a PWM frame (tick with counter at 255)
//   pwm_g/pwm_b/pwm_r     registered PWM bits, one clock behind the counter
module rgb_pwm_gen
  import rgb_sched_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic              hw_clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DUTY_W-1:0] duty_g,
  input  logic [DUTY_W-1:0] duty_b,
  input  logic [DUTY_W-1:0] duty_r,
  output logic              frame_end,
  output logic              pwm_g,
  output logic              pwm_b,
  output logic              pwm_r
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0]     presc_d, presc_q;
  logic [DUTY_W-1:0] cnt_d, cnt_q;
  logic [2:0]        pwm_d, pwm_q;
  logic              tick;
  always_comb begin
    tick      = presc_q == PW'(PRESCALE - 1);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    cnt_d     = tick ? cnt_q + 1'b1 : cnt_q;
    frame_end = tick && cnt_q == {DUTY_W{1'b1}};
    pwm_d     = {en && cnt_q < duty_r, en && cnt_q < duty_b, en && cnt_q < duty_g};
  end
  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      pwm_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_d;
    end
  end
  assign {pwm_r, pwm_b, pwm_g} = pwm_q;
endmodule

// File: rtl/rgb_led_sched.sv
// rgb_led_sched: fixed-priority RGB LED arbiter with frame-aligned ownership, solid/blink (optional breathe)
//   hw_clk, rst_n       clock, async active-low reset
//   req                 level request per requester, index 0 highest priority
//   req_duty            per requester {red[23:16], blue[15:8], green[7:0]}
//   req_mode            per requester 2-bit mode (solid, blink, breathe, reserved=solid)
//   gnt                 one-hot current owner, 0 when idle
//   led_en              LED driver enable, 1 whenever not idle
//   pwm_g/pwm_b/pwm_r   PWM bits for RGB0/RGB1/RGB2
// Optional feature: define RGB_SCHED_BREATHE_EN to make mode 10 a triangular breathe ramp;
// otherwise mode 10 is treated as solid and no level logic exists.
module rgb_led_sched
  import rgb_sched_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int PRESCALE     = 4,
  parameter int BLINK_FRAMES = 24
) (
  input  logic              hw_clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [24*NREQ-1:0] req_duty,
  input  logic [2*NREQ-1:0] req_mode,
  output logic [NREQ-1:0]   gnt,
  output logic              led_en,
  output logic              pwm_g,
  output logic              pwm_b,
  output logic              pwm_r
);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [NREQ-1:0] gnt_n, gnt_d, gnt_q;
  logic [23:0]     duty_n, duty_d, duty_q, duty_eff;
  mode_t           mode_n;
  state_t          state_d, state_q;
  logic            led_en_d, led_en_q;
  logic [BW-1:0]   blink_d, blink_q;
  logic            frame_end;
  // Descending scan so the lowest requesting index is the last (winning) assignment
  always_comb begin
    gnt_n  = '0;
    duty_n = '0;
    mode_n = MODE_SOLID;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_n  = NREQ'(1) << i;
        duty_n = req_duty[24*i +: 24];
        mode_n = mode_t'(req_mode[2*i +: 2]);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    duty_d  = duty_q;
    blink_d = blink_q;
    if (frame_end) begin
      gnt_d  = gnt_n;
      duty_d = duty_n;
      if (gnt_n == '0) begin
        state_d = ST_IDLE;
        blink_d = '0;
      end else if (gnt_n != gnt_q || mode_n != MODE_BLINK) begin
        state_d = ST_ON;
        blink_d = '0;
      end else if (blink_q == BW'(BLINK_FRAMES - 1)) begin
        state_d = state_q == ST_ON ? ST_OFF : ST_ON;
        blink_d = '0;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end
    led_en_d = state_d != ST_IDLE;
  end
`ifdef RGB_SCHED_BREATHE_EN
  mode_t             mode_d, mode_q;
  logic [DUTY_W-1:0] level_d, level_q;
  logic              up_d, up_q;
  // Triangle 0..255..0; restarts from 0 whenever the owner changes or leaves breathe mode
  always_comb begin
    mode_d  = frame_end ? mode_n : mode_q;
    level_d = level_q;
    up_d    = up_q;
    if (frame_end) begin
      if (gnt_n != gnt_q || mode_n != MODE_BREATHE) begin
        level_d = '0;
        up_d    = 1'b1;
      end else if (up_q) begin
        level_d = level_q == 8'hFF ? 8'hFE : level_q + 1'b1;
        up_d    = level_q != 8'hFF;
      end else begin
        level_d = level_q == 8'h00 ? 8'h01 : level_q - 1'b1;
        up_d    = level_q == 8'h00;
      end
    end
    duty_eff = mode_q == MODE_BREATHE ?
               {scale_duty(duty_q[R_OFS +: DUTY_W], level_q),
                scale_duty(duty_q[B_OFS +: DUTY_W], level_q),
                scale_duty(duty_q[G_OFS +: DUTY_W], level_q)} : duty_q;
  end
`else
  assign duty_eff = duty_q;
`endif
  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      duty_q   <= '0;
      blink_q  <= '0;
      led_en_q <= 1'b0;
`ifdef RGB_SCHED_BREATHE_EN
      mode_q   <= MODE_SOLID;
      level_q  <= '0;
      up_q     <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      duty_q   <= duty_d;
      blink_q  <= blink_d;
      led_en_q <= led_en_d;
`ifdef RGB_SCHED_BREATHE_EN
      mode_q   <= mode_d;
      level_q  <= level_d;
      up_q     <= up_d;
`endif
    end
  end
  rgb_pwm_gen #(.PRESCALE(PRESCALE)) u_pwm (
    .hw_clk   (hw_clk),
    .rst_n    (rst_n),
    .en       (state_q == ST_ON),
    .duty_g   (duty_eff[G_OFS +: DUTY_W]),
    .duty_b   (duty_eff[B_OFS +: DUTY_W]),
    .duty_r   (duty_eff[R_OFS +: DUTY_W]),
    .frame_end(frame_end),
    .pwm_g    (pwm_g),
    .pwm_b    (pwm_b),
    .pwm_r    (pwm_r)
  );
  assign gnt    = gnt_q;
  assign led_en = led_en_q;
endmodule

// File: tb/tb_rgb_led_sched.sv
// tb_rgb_led_sched: directed checks of arbitration, frame-aligned handover, PWM counts, blink and reset
module tb_rgb_led_sched;
  logic        hw_clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [95:0] req_duty;
  logic [7:0]  req_mode;
  logic [3:0]  gnt;
  logic        led_en, pwm_g, pwm_b, pwm_r;
  int          cyc, checks, errs;
  int          r, g, b;
  always #5 hw_clk = ~hw_clk;
  rgb_led_sched #(.NREQ(4), .PRESCALE(1), .BLINK_FRAMES(2)) dut (
    .hw_clk  (hw_clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_duty(req_duty),
    .req_mode(req_mode),
    .gnt     (gnt),
    .led_en  (led_en),
    .pwm_g   (pwm_g),
    .pwm_b   (pwm_b),
    .pwm_r   (pwm_r)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge hw_clk);
    #1;
    cyc++;
  endtask
  task automatic goto(input int n);
    while (cyc < n) step();
  endtask
  task automatic count_frame(output int rc, output int gc, output int bc);
    rc = 0; gc = 0; bc = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      rc += int'(pwm_r); gc += int'(pwm_g); bc += int'(pwm_b);
    end
  endtask
  initial begin
    int exp_r[4];
    checks = 0; errs = 0; cyc = 0;
    rst_n = 1'b0; req = 4'hF; req_mode = '0; req_duty = '0;
    req_duty[48 +: 24] = {8'h40, 8'hFF, 8'h00};
    repeat (3) step();
    chk("rst_gnt", gnt, 4'h0);
    chk("rst_led_en", led_en, 1'b0);
    chk("rst_pwm", {pwm_r, pwm_g, pwm_b}, 3'b000);
    rst_n = 1'b1;
    cyc = 0;
    goto(255);
    chk("pre_frame_gnt", gnt, 4'h0);
    chk("pre_frame_led_en", led_en, 1'b0);
    step();
    chk("first_frame_gnt", gnt, 4'b0001);
    req = 4'b0100;
    goto(512);
    chk("solid_gnt", gnt, 4'b0100);
    chk("solid_led_en", led_en, 1'b1);
    count_frame(r, g, b);
    chk("solid_r", r, 64);
    chk("solid_b", b, 255);
    chk("solid_g", g, 0);
    goto(868);
    req[0] = 1'b1;
    chk("preempt_wait_gnt", gnt, 4'b0100);
    goto(1023);
    chk("preempt_last_gnt", gnt, 4'b0100);
    step();
    chk("preempt_gnt", gnt, 4'b0001);
    goto(1030);
    req = 4'b0010;
    req_mode[3:2] = 2'b01;
    req_duty[24 +: 24] = {8'h80, 8'h80, 8'h80};
    goto(1280);
    chk("blink_gnt", gnt, 4'b0010);
    for (int f = 0; f < 4; f++) begin
      chk("blink_led_en", led_en, 1'b1);
      count_frame(r, g, b);
      chk("blink_r", r, f < 2 ? 128 : 0);
      chk("blink_g", g, f < 2 ? 128 : 0);
    end
    chk("blink_on_again_gnt", gnt, 4'b0010);
    goto(2400);
    req = 4'b0000;
    goto(2410);
    chk("drop_run_pwm_r", pwm_r, 1'b1);
    goto(2559);
    chk("drop_hold_gnt", gnt, 4'b0010);
    chk("drop_hold_led_en", led_en, 1'b1);
    step();
    chk("drop_gnt", gnt, 4'h0);
    chk("drop_led_en", led_en, 1'b0);
    step();
    chk("drop_pwm", {pwm_r, pwm_g, pwm_b}, 3'b000);
    req = 4'b1000;
    req_mode[7:6] = 2'b10;
    req_duty[72 +: 24] = {8'hFF, 8'h00, 8'h00};
`ifdef RGB_SCHED_BREATHE_EN
    exp_r = '{0, 0, 1, 2};
`else
    exp_r = '{255, 255, 255, 255};
`endif
    goto(2816);
    chk("mode10_gnt", gnt, 4'b1000);
    for (int f = 0; f < 4; f++) begin
      count_frame(r, g, b);
      chk("mode10_r", r, exp_r[f]);
      chk("mode10_g", g, 0);
    end
`ifdef RGB_SCHED_BREATHE_EN
    goto(2816 + 256 * 255);
    count_frame(r, g, b);
    chk("breathe_peak_r", r, 254);
`endif
    repeat (100) step();
    chk("pre_reset_pwm_r", pwm_r, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", gnt, 4'h0);
    chk("async_rst_led_en", led_en, 1'b0);
    chk("async_rst_pwm", {pwm_r, pwm_g, pwm_b}, 3'b000);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
